// File: rtl/ksz_bus_pkg.sv
// -----------------------------------------------------------------------------
// ksz_bus_pkg
// Shared definitions for the KSZ8851-16MLL host bus engine and the
// transmission / reception / init sequencers that drive it.
//   bus_state_e : phase encodings exported on ksz_bus_io.state; the
//                 sequencers decode these values directly.
//   REG_*       : register byte offsets used by the sequencers.
//   be_encode   : byte-enable nibble for an access.
//   cmd_word    : 16-bit command (address) word placed on SD in Addr0.
// -----------------------------------------------------------------------------
package ksz_bus_pkg;

   typedef enum logic [3:0] {
      ST_ADDR0  = 4'd0,
      ST_ADDR1  = 4'd1,
      ST_ADDR2  = 4'd2,
      ST_READ0  = 4'd3,
      ST_READ1  = 4'd4,
      ST_READ2  = 4'd5,
      ST_WRITE0 = 4'd6,
      ST_WRITE1 = 4'd7,
      ST_WRITE2 = 4'd8,
      ST_WAIT   = 4'd9
   } bus_state_e;

   localparam logic [7:0] REG_TXMIR = 8'h78;  // TXQ memory information
   localparam logic [7:0] REG_TXQCR = 8'h80;  // TXQ command
   localparam logic [7:0] REG_RXQCR = 8'h82;  // RXQ command
   localparam logic [7:0] REG_IER   = 8'h90;  // interrupt enable

   // Only the two low offset bits select byte lanes.
   // Word access: lanes 1:0 or 3:2. Byte access: one lane.
   function automatic logic [3:0] be_encode(input logic [1:0] offset,
                                             input logic       length);
      logic [3:0] be;
      if (length) begin
         be = offset[1] ? 4'b1100 : 4'b0011;
      end else begin
         be = 4'b0001 << offset;
      end
      return be;
   endfunction

   // {BE[3:0], 4'b0, dword-aligned address}
   function automatic logic [15:0] cmd_word(input logic [7:0] offset,
                                            input logic       length);
      return {be_encode(offset[1:0], length), 4'b0000, offset[7:2], 2'b00};
   endfunction

endpackage

// File: rtl/ksz_bus_io.sv
// -----------------------------------------------------------------------------
// ksz_bus_io
// Bus engine for the KSZ8851-16MLL 16-bit asynchronous host interface.
// Executes one register access (address phase + read or write data phase)
// or one data-only write per request, and exports its phase on `state` so
// that upstream sequencers can step themselves on it.
//
// Ports
//   sysclk, reset          : clock, synchronous active-high reset
//   offset, length, WR     : register byte address, 1=16-bit/0=8-bit, 1=write
//   writeData              : write word, captured on entry to Write0
//   NewCommand             : start / continue a register access
//   Dummy_Write            : data-only write (QMU DMA burst), no address phase
//   readData               : last word read, held until the next read
//   state                  : current phase (ksz_bus_pkg::bus_state_e)
//   eth_csn/rdn/wrn/cmd    : chip control pins (csn/rdn/wrn active low)
//   eth_sd_out, eth_sd_oe  : SD drive value and enable for the pad tristate
//   eth_sd_in              : SD pad input
//
// Every pin output is a flop computed from the *next* phase, so pin values
// always line up with the cycles in which `state` shows that phase.
// -----------------------------------------------------------------------------
module ksz_bus_io
   import ksz_bus_pkg::*;
#(
   parameter int STROBE_EXT = 0
) (
   input  logic        sysclk,
   input  logic        reset,
   input  logic [7:0]  offset,
   input  logic        length,
   input  logic        WR,
   input  logic [15:0] writeData,
   input  logic        NewCommand,
   input  logic        Dummy_Write,
   output logic [15:0] readData,
   output logic [3:0]  state,
   output logic        eth_csn,
   output logic        eth_rdn,
   output logic        eth_wrn,
   output logic        eth_cmd,
   output logic [15:0] eth_sd_out,
   output logic        eth_sd_oe,
   input  logic [15:0] eth_sd_in
);

   localparam int EXT_W = (STROBE_EXT > 0) ? $clog2(STROBE_EXT + 1) : 1;
   localparam logic [EXT_W-1:0] EXT_MAX = EXT_W'(STROBE_EXT);

   bus_state_e       state_q, state_d;
   logic [EXT_W-1:0] ext_q, ext_d;
   logic [15:0]      read_data_q, read_data_d;
   logic [15:0]      sd_out_q, sd_out_d;
   logic             csn_q, csn_d;
   logic             rdn_q, rdn_d;
   logic             wrn_q, wrn_d;
   logic             cmd_q, cmd_d;
   logic             sd_oe_q, sd_oe_d;

   logic             ext_done;
   logic             in_ext_d;

   assign ext_done = (ext_q == EXT_MAX);

   always_comb begin
      state_d     = state_q;
      ext_d       = '0;
      read_data_d = read_data_q;
      sd_out_d    = sd_out_q;

      case (state_q)
         // X0 phases: first cycle strobe high, then STROBE_EXT cycles with
         // the strobe low (counter nonzero) before the X1 cycle.
         ST_ADDR0: begin
            if (ext_done) state_d = ST_ADDR1;
            else          ext_d   = ext_q + 1'b1;
         end
         ST_ADDR1: state_d = ST_ADDR2;
         ST_ADDR2: begin
            if (WR) begin
               state_d  = ST_WRITE0;
               sd_out_d = writeData;
            end else begin
               state_d  = ST_READ0;
            end
         end
         ST_READ0: begin
            if (ext_done) state_d = ST_READ1;
            else          ext_d   = ext_q + 1'b1;
         end
         ST_READ1: begin
            state_d     = ST_READ2;
            read_data_d = eth_sd_in;   // last cycle with rdn low
         end
         ST_WRITE0: begin
            if (ext_done) state_d = ST_WRITE1;
            else          ext_d   = ext_q + 1'b1;
         end
         ST_WRITE1: state_d = ST_WRITE2;
         // Decision points: Wait and the data X2 phases share one rule,
         // which lets bursts and back-to-back accesses skip Wait.
         ST_READ2, ST_WRITE2, ST_WAIT: begin
            if (Dummy_Write) begin
               state_d  = ST_WRITE0;
               sd_out_d = writeData;
            end else if (NewCommand) begin
               state_d  = ST_ADDR0;
               sd_out_d = cmd_word(offset, length);
            end else begin
               state_d  = ST_WAIT;
            end
         end
         default: state_d = ST_WAIT;
      endcase

      // Pin values for the phase being entered.
      in_ext_d = (ext_d != '0);
      csn_d    = (state_d == ST_WAIT);
      cmd_d    = (state_d inside {ST_ADDR0, ST_ADDR1, ST_ADDR2});
      sd_oe_d  = !(state_d inside {ST_WAIT, ST_READ0, ST_READ1, ST_READ2});
      rdn_d    = !((state_d == ST_READ1) ||
                   ((state_d == ST_READ0) && in_ext_d));
      wrn_d    = !((state_d == ST_ADDR1) || (state_d == ST_WRITE1) ||
                   (((state_d == ST_ADDR0) || (state_d == ST_WRITE0)) && in_ext_d));
      if (!sd_oe_d) begin
         sd_out_d = '0;
      end
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         state_q     <= ST_WAIT;
         ext_q       <= '0;
         read_data_q <= '0;
         sd_out_q    <= '0;
         csn_q       <= 1'b1;
         rdn_q       <= 1'b1;
         wrn_q       <= 1'b1;
         cmd_q       <= 1'b0;
         sd_oe_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         ext_q       <= ext_d;
         read_data_q <= read_data_d;
         sd_out_q    <= sd_out_d;
         csn_q       <= csn_d;
         rdn_q       <= rdn_d;
         wrn_q       <= wrn_d;
         cmd_q       <= cmd_d;
         sd_oe_q     <= sd_oe_d;
      end
   end

   assign readData   = read_data_q;
   assign state      = state_q;
   assign eth_csn    = csn_q;
   assign eth_rdn    = rdn_q;
   assign eth_wrn    = wrn_q;
   assign eth_cmd    = cmd_q;
   assign eth_sd_out = sd_out_q;
   assign eth_sd_oe  = sd_oe_q;

endmodule

// File: tb/tb_ksz_bus_io.sv
// -----------------------------------------------------------------------------
// tb_ksz_bus_io
// Two engines: d0 with STROBE_EXT=0 and d2 with STROBE_EXT=2. The stimulus
// expands each access it issues into the per-cycle pin picture the bus
// protocol requires and queues it; a compare process checks both engines
// on every falling edge against the queue head (or the idle picture when
// nothing is queued).
// -----------------------------------------------------------------------------
module tb_ksz_bus_io;

   typedef struct packed {
      logic [3:0]  st;
      logic        csn;
      logic        rdn;
      logic        wrn;
      logic        cmd;
      logic        oe;
      logic [15:0] sd;
      logic [15:0] rd;
   } rec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  offset;
   logic        length;
   logic        WR;
   logic [15:0] writeData;
   logic [15:0] eth_sd_in;
   logic        nc0, nc2, dw0, dw2;

   logic [15:0] rdo0, rdo2, sdo0, sdo2;
   logic [3:0]  st0, st2;
   logic        csn0, rdn0, wrn0, cmd0, oe0;
   logic        csn2, rdn2, wrn2, cmd2, oe2;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   rec_t        q0[$];
   rec_t        q2[$];
   logic [15:0] last0 = 16'h0;
   logic [15:0] last2 = 16'h0;

   always #5 clk = ~clk;

   ksz_bus_io #(.STROBE_EXT(0)) dut0 (
      .sysclk(clk), .reset(reset), .offset(offset), .length(length), .WR(WR),
      .writeData(writeData), .NewCommand(nc0), .Dummy_Write(dw0),
      .readData(rdo0), .state(st0), .eth_csn(csn0), .eth_rdn(rdn0),
      .eth_wrn(wrn0), .eth_cmd(cmd0), .eth_sd_out(sdo0), .eth_sd_oe(oe0),
      .eth_sd_in(eth_sd_in)
   );

   ksz_bus_io #(.STROBE_EXT(2)) dut2 (
      .sysclk(clk), .reset(reset), .offset(offset), .length(length), .WR(WR),
      .writeData(writeData), .NewCommand(nc2), .Dummy_Write(dw2),
      .readData(rdo2), .state(st2), .eth_csn(csn2), .eth_rdn(rdn2),
      .eth_wrn(wrn2), .eth_cmd(cmd2), .eth_sd_out(sdo2), .eth_sd_oe(oe2),
      .eth_sd_in(eth_sd_in)
   );

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic rec_t mk(input int st, input bit csn, input bit rdn, input bit wrn,
                               input bit cmd, input bit oe, input logic [15:0] sd,
                               input logic [15:0] rd);
      rec_t r;
      r.st = 4'(st); r.csn = csn; r.rdn = rdn; r.wrn = wrn;
      r.cmd = cmd; r.oe = oe; r.sd = sd; r.rd = rd;
      return r;
   endfunction

   function automatic rec_t idle_rec(input logic [15:0] rd);
      return mk(9, 1, 1, 1, 0, 0, 16'h0, rd);
   endfunction

   task automatic cmp_rec(input string tag, input rec_t a, input rec_t e);
      chk($sformatf("%s.state@%0d", tag, cyc), 16'(a.st), 16'(e.st));
      chk($sformatf("%s.csn@%0d", tag, cyc), 16'(a.csn), 16'(e.csn));
      chk($sformatf("%s.rdn@%0d", tag, cyc), 16'(a.rdn), 16'(e.rdn));
      chk($sformatf("%s.wrn@%0d", tag, cyc), 16'(a.wrn), 16'(e.wrn));
      chk($sformatf("%s.cmd@%0d", tag, cyc), 16'(a.cmd), 16'(e.cmd));
      chk($sformatf("%s.oe@%0d", tag, cyc), 16'(a.oe), 16'(e.oe));
      chk($sformatf("%s.readData@%0d", tag, cyc), a.rd, e.rd);
      if (e.oe) chk($sformatf("%s.sd_out@%0d", tag, cyc), a.sd, e.sd);
   endtask

   // ---------------- behavioural model ----------------
   // Command word from the addressing rules: byte-enable nibble in the top
   // four bits, dword-aligned byte address in the low byte.
   function automatic logic [15:0] model_cmd(input logic [7:0] off, input logic len);
      int lane, be;
      lane = int'(off) % 4;
      if (len) be = (lane >= 2) ? 12 : 3;
      else     be = 1 << lane;
      return 16'(be * 4096 + (int'(off) / 4) * 4);
   endfunction

   task automatic push(input int which, input rec_t r);
      if (which == 0) q0.push_back(r);
      else            q2.push_back(r);
   endtask

   // One phase group: X0 for 1+ext cycles (strobe low only in the extra
   // cycles), X1 one cycle strobe low, X2 one cycle strobe high.
   task automatic push_phase(input int which, input int ext, input int x0, input bit is_rd,
                             input bit cmd, input bit oe, input logic [15:0] sd,
                             input logic [15:0] rd_before, input logic [15:0] rd_after,
                             input bit upto_x1);
      for (int i = 0; i <= ext; i++)
         push(which, mk(x0, 0, !(is_rd && i > 0), !(!is_rd && i > 0), cmd, oe, sd, rd_before));
      push(which, mk(x0 + 1, 0, !is_rd, is_rd, cmd, oe, sd, rd_before));
      if (!upto_x1) push(which, mk(x0 + 2, 0, 1, 1, cmd, oe, sd, rd_after));
   endtask

   task automatic push_data(input int which, input int ext, input bit wr,
                            input logic [15:0] data, input bit upto_x1);
      logic [15:0] last;
      last = (which == 0) ? last0 : last2;
      if (wr) begin
         push_phase(which, ext, 6, 0, 0, 1, data, last, last, upto_x1);
      end else begin
         push_phase(which, ext, 3, 1, 0, 0, 16'h0, last, data, upto_x1);
         if (!upto_x1) begin
            if (which == 0) last0 = data;
            else            last2 = data;
         end
      end
   endtask

   task automatic push_access(input int which, input int ext, input bit wr,
                              input logic [15:0] cw, input logic [15:0] data,
                              input bit upto_x1);
      logic [15:0] last;
      last = (which == 0) ? last0 : last2;
      push_phase(which, ext, 0, 0, 1, 1, cw, last, last, 0);
      push_data(which, ext, wr, data, upto_x1);
   endtask

   // ---------------- compare process ----------------
   initial begin
      rec_t a, e;
      repeat (2) @(posedge clk);
      forever begin
         @(negedge clk);
         cyc++;
         e = (q0.size() != 0) ? q0.pop_front() : idle_rec(last0);
         a = mk(int'(st0), csn0, rdn0, wrn0, cmd0, oe0, sdo0, rdo0);
         cmp_rec("d0", a, e);
         e = (q2.size() != 0) ? q2.pop_front() : idle_rec(last2);
         a = mk(int'(st2), csn2, rdn2, wrn2, cmd2, oe2, sdo2, rdo2);
         cmp_rec("d2", a, e);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((q0.size() != 0 || q2.size() != 0) && n < 200) begin
         step();
         n++;
      end
      if (q0.size() != 0 || q2.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL wait_idle: got %0d/%0d queued expected 0", q0.size(), q2.size());
         q0.delete();
         q2.delete();
      end
   endtask

   task automatic do_single(input logic [7:0] off, input bit len, input bit wr,
                            input logic [15:0] wd, input logic [15:0] sdin,
                            input logic [15:0] cw);
      offset = off; length = len; WR = wr; writeData = wd; eth_sd_in = sdin;
      nc0 = 1'b1;
      push_access(0, 0, wr, cw, wr ? wd : sdin, 0);
      step();
      nc0 = 1'b0;
      wait_idle();
      step();
      $display("access off=%h len=%0d wr=%0d cw=%h done, checks=%0d", off, len, wr, cw, checks);
   endtask

   initial begin
      logic [15:0] words [3];
      words[0] = 16'h8000; words[1] = 16'h0020; words[2] = 16'h5548;

      reset = 1'b1; offset = 8'h0; length = 1'b0; WR = 1'b0;
      writeData = 16'h0; eth_sd_in = 16'h0;
      nc0 = 1'b0; nc2 = 1'b0; dw0 = 1'b0; dw2 = 1'b0;
      repeat (3) step();
      chk("reset.state", 16'(st0), 16'd9);
      chk("reset.sd_out", sdo0, 16'h0000);
      chk("reset.readData", rdo0, 16'h0000);
      chk("reset.csn", 16'(csn0), 16'd1);
      chk("reset.ext_state", 16'(st2), 16'd9);
      reset = 1'b0;
      step();

      // Word read, word write, byte write with hand-derived command words.
      do_single(8'h78, 1, 0, 16'h0000, 16'h1ABC, 16'h3078);
      chk("read.readData", rdo0, 16'h1ABC);
      do_single(8'h90, 1, 1, 16'h6000, 16'h0000, 16'h3090);
      do_single(8'h83, 0, 1, 16'h00A5, 16'h0000, 16'h8080);

      // Back-to-back: word read, then byte write straight from Read2.
      offset = 8'h82; length = 1'b1; WR = 1'b0; eth_sd_in = 16'h5A5A; nc0 = 1'b1;
      push_access(0, 0, 0, model_cmd(8'h82, 1'b1), 16'h5A5A, 0);
      repeat (6) step();
      offset = 8'h81; length = 1'b0; WR = 1'b1; writeData = 16'h00C3;
      push_access(0, 0, 1, model_cmd(8'h81, 1'b0), 16'h00C3, 0);
      step();
      nc0 = 1'b0;
      wait_idle();
      step();
      $display("back-to-back read/write done, checks=%0d", checks);

      // Dummy write burst: new data loaded while in each Write2.
      dw0 = 1'b1; writeData = words[0];
      push_data(0, 0, 1, words[0], 0);
      for (int w = 0; w < 3; w++) begin
         repeat (3) step();
         if (w < 2) begin
            writeData = words[w + 1];
            push_data(0, 0, 1, words[w + 1], 0);
         end else begin
            dw0 = 1'b0;
         end
      end
      wait_idle();
      step();
      $display("dummy burst of 3 words done, checks=%0d", checks);

      // Extended-strobe read on the STROBE_EXT=2 engine.
      offset = 8'h80; length = 1'b1; WR = 1'b0; eth_sd_in = 16'hBEEF; nc2 = 1'b1;
      push_access(2, 2, 0, model_cmd(8'h80, 1'b1), 16'hBEEF, 0);
      step();
      nc2 = 1'b0;
      wait_idle();
      step();
      chk("ext.readData", rdo2, 16'hBEEF);
      $display("STROBE_EXT=2 read done, checks=%0d", checks);

      // Reset while the write strobe is low in Write1.
      offset = 8'h78; length = 1'b1; WR = 1'b1; writeData = 16'h1234; nc0 = 1'b1;
      push_access(0, 0, 1, model_cmd(8'h78, 1'b1), 16'h1234, 1);
      step();
      nc0 = 1'b0;
      wait_idle();
      reset = 1'b1;
      last0 = 16'h0;
      last2 = 16'h0;
      step();
      chk("rst.state", 16'(st0), 16'd9);
      chk("rst.wrn", 16'(wrn0), 16'd1);
      chk("rst.csn", 16'(csn0), 16'd1);
      chk("rst.oe", 16'(oe0), 16'd0);
      chk("rst.readData", rdo0, 16'h0000);
      reset = 1'b0;
      repeat (3) step();
      $display("reset during Write1 done, checks=%0d", checks);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ksz_bus_io.md
Name: ksz_bus_io

Overview:
- Low-level bus engine for the KSZ8851-16MLL 16-bit host interface.
- It executes one register access or data-only (dummy) write per request, driving the chip's CSn/RDn/WRn/CMD/SD pins.
- It sits directly downstream of the transmission, reception and init sequencers, which issue offset/length/WR/writeData/NewCommand/Dummy_Write and sequence themselves on the state it exports.
- It returns readData.

Parameters:
- STROBE_EXT, 0: extra cycles added to each X0 phase (Addr0/Read0/Write0). RDn/WRn go low during these extra cycles, lengthening the strobe.

Ports:
- sysclk in 1: system clock.
- reset in 1: synchronous, active-high reset.
- offset in 8: register byte address.
- length in 1: 1 = 16-bit access, 0 = 8-bit access.
- WR in 1: 1 = write, 0 = read.
- writeData in 16: write data, sampled in Write0.
- NewCommand in 1: start or continue a register access.
- Dummy_Write in 1: 1 = data-only write burst (QMU DMA), no address phase.
- readData out 16: last read word, registered.
- state out 4: current phase. Encodings: Addr0=0, Addr1=1, Addr2=2, Read0=3, Read1=4, Read2=5, Write0=6, Write1=7, Write2=8, Wait=9.
- eth_csn out 1: chip select, active low.
- eth_rdn out 1: read strobe, active low.
- eth_wrn out 1: write strobe, active low.
- eth_cmd out 1: 1 = command (address) cycle, 0 = data cycle.
- eth_sd_out out 16: SD bus drive value.
- eth_sd_oe out 1: SD output enable; the top-level tristate uses it.
- eth_sd_in in 16: SD bus sampled value.

Behaviour:
- Reset values: state=Wait, readData=0, csn=rdn=wrn=1, cmd=0, sd_out=0, sd_oe=0. The extension counter is cleared.
- Reset asserted mid-transaction aborts at the next edge. No partial strobe low is held.
- All pin outputs are registered and aligned with state: the values listed for phase X appear in the same cycles that state==X.
- Contract: Addr1, Addr2, Read1, Read2, Write1 and Write2 each last exactly one cycle. Upstream sequencers use them as single-cycle events.
- X0 phases last 1+STROBE_EXT cycles.
- Wait:
  - Pins idle.
  - Dummy_Write=1 -> Write0. This takes priority over NewCommand.
  - Else NewCommand=1 -> Addr0.
  - Else stay in Wait.
- Address phase:
  - Addr0: csn=0, cmd=1, sd_oe=1, sd_out={BE[3:0],4'b0,offset[7:2],2'b00}.
  - Byte enables: length=1 gives BE=offset[1] ? 4'b1100 : 4'b0011. length=0 gives BE=4'b0001<<offset[1:0].
  - The command word is latched at Addr0 entry.
  - wrn=0 in Addr1 and in the extension cycles of Addr0. Addr2: wrn=1.
  - Addr2 -> Write0 if WR=1, else Read0. WR is sampled in Addr2.
- Read phase:
  - Read0: csn=0, cmd=0, sd_oe=0.
  - rdn=0 in the extension cycles of Read0 and in Read1.
  - readData<=eth_sd_in on the Read1->Read2 edge. It is valid from the first Read2 cycle and holds until the next read.
  - Read2: rdn=1.
- Write phase:
  - Write0: csn=0, cmd=0, sd_oe=1, sd_out=writeData sampled at Write0 entry. writeData is loaded by upstream in the preceding X2 or Addr0.
  - wrn=0 in the extension cycles of Write0 and in Write1. Write2: wrn=1, data held.
- X2 exit rule (Addr2 excepted), evaluated in Read2/Write2:
  - Dummy_Write=1 -> Write0 (burst continues).
  - Else NewCommand=1 -> Addr0 (back-to-back access).
  - Else -> Wait.
- Dummy_Write changes take effect only at an X2 or Wait decision. A mid-phase change does not alter the current access.
- Byte-read data is returned unshifted on the lane selected by BE; upstream selects the byte.
- Minimum access length, Wait-to-Wait (STROBE_EXT=0): 7 cycles. Each burst word costs 3+STROBE_EXT cycles.
- csn deasserts only in Wait.

Decomposition:
- Shared package ksz_bus_pkg holds:
  - the state encodings above, as the single source shared with the transmission, reception and init sequencers;
  - the register offsets 0x78, 0x82, 0x80 and 0x90;
  - a be_encode(offset, length) function.
- No sub-module: a single FSM plus an extension counter ($clog2(STROBE_EXT+1) bits, min 1).

Test Plan:
- Word read: offset=0x78, length=1, WR=0, NewCommand pulse, sd_in=0x1ABC.
  - Expect Addr0 sd_out=0x3078, cmd=1.
  - Expect state sequence 9,0,1,2,3,4,5,9.
  - Expect readData=0x1ABC from Read2.
  - Expect rdn low only in Read1.
- Word write: offset=0x90, WR=1, writeData=0x6000.
  - Expect Addr0 sd_out=0x3090.
  - Expect Write0–2 sd_out=0x6000, oe=1, wrn low only in Write1, then Wait.
- Byte write: offset=0x83, length=0, WR=1.
  - Expect command word 0x8080 (BE=1000).
- Dummy burst: Dummy_Write=1 for 3 words, writeData 0x8000, 0x0020, 0x5548 changed in each Write2.
  - Expect 3 Write0–Write2 loops with cmd=0 throughout and no Addr states.
  - Expect return to Wait after Dummy_Write drops.
- STROBE_EXT=2 read:
  - Expect Read0 for 3 cycles, rdn low for 3 cycles (2 ext + Read1).
  - Expect Read1 and Read2 single cycle.
- Reset asserted during Write1:
  - Expect next cycle state=9, wrn=csn=1, oe=0, readData=0.
